// File: rtl/fpu_pkg.sv
// fpu_pkg: opcodes, controller state encoding and operand width shared by FPU-sharing blocks
package fpu_pkg;
  localparam int FPU_W = 32;
  localparam logic [1:0] FPU_ADD = 2'b00;
  localparam logic [1:0] FPU_MUL = 2'b01;
  typedef logic [1:0] state_t;
  localparam state_t IDLE    = 2'd0;
  localparam state_t BUSY    = 2'd1;
  localparam state_t RELEASE = 2'd2;
  localparam state_t RESP    = 2'd3;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, first set request at or above ptr with wrap
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);
  logic [NREQ-1:0] mask, hi, pick;
  logic [IW-1:0] ix [NREQ+1];
  assign ix[0] = '0;
  for (genvar i = 0; i < NREQ; i++) begin : g_req
    assign mask[i] = IW'(i) >= ptr;
    assign ix[i+1] = ix[i] | (grant[i] ? IW'(i) : '0);
  end
  assign idx = ix[NREQ];
  // prefer requesters at/above ptr, otherwise wrap to the lowest; isolate lowest set bit
  always_comb begin
    hi = req & mask;
    pick = |hi ? hi : req;
    grant = pick & (~pick + NREQ'(1));
  end
endmodule

// File: rtl/fpu_share_ctrl.sv
// fpu_share_ctrl: round-robin sharing of one start/done FPU between NREQ requesters with watchdog
module fpu_share_ctrl import fpu_pkg::*; #(
  parameter int NREQ = 2,
  parameter int W = FPU_W,
  parameter int TIMEOUT = 64,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [2*NREQ-1:0] req_op,
  input  logic [W*NREQ-1:0] req_a,
  input  logic [W*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IW-1:0]     rsp_id,
  output logic [W-1:0]      rsp_data,
  output logic              rsp_err,
  output logic              fpu_start,
  output logic [1:0]        fpu_op,
  output logic [W-1:0]      fpu_a,
  output logic [W-1:0]      fpu_b,
  input  logic [W-1:0]      fpu_out,
  input  logic              fpu_done
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] WD_MAX = CW'(TIMEOUT - 1);
  state_t state, state_n;
  logic [IW-1:0] rr_ptr, gid, g_idx;
  logic [NREQ-1:0] grant;
  logic [CW-1:0] wd_cnt;
  logic ready_en, acc, wd_hit;
  logic [1:0] op_arr [NREQ];
  logic [W-1:0] a_arr [NREQ];
  logic [W-1:0] b_arr [NREQ];
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign op_arr[i] = req_op[2*i +: 2];
    assign a_arr[i] = req_a[W*i +: W];
    assign b_arr[i] = req_b[W*i +: W];
  end
  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req(req_valid),
    .ptr(rr_ptr),
    .grant(grant),
    .idx(g_idx)
  );
  assign req_ready = (state == IDLE && ready_en && !fpu_done) ? grant : '0;
  assign acc = |(req_valid & req_ready);
  assign wd_hit = wd_cnt == WD_MAX;
  // state register
  always_ff @(posedge clk) begin
    state <= reset ? IDLE : state_n;
  end
  // next state: accept, wait done or watchdog, wait done release, hand off response
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = acc ? BUSY : IDLE;
      BUSY:    state_n = (fpu_done || wd_hit) ? RELEASE : BUSY;
      RELEASE: state_n = (!fpu_done || wd_hit) ? RESP : RELEASE;
      default: state_n = rsp_ready ? IDLE : RESP;
    endcase
  end
  // outputs decoded from state so reset drops fpu_start on the very next cycle
  always_comb begin
    fpu_start = state == BUSY;
    rsp_valid = state == RESP;
    rsp_id = gid;
  end
  // operand capture, pointer advance, watchdog count and result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_en <= 1'b0;
      rr_ptr <= '0;
      gid <= '0;
      wd_cnt <= '0;
      fpu_op <= '0;
      fpu_a <= '0;
      fpu_b <= '0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      case (state)
        IDLE: if (acc) begin
          fpu_op <= op_arr[g_idx];
          fpu_a <= a_arr[g_idx];
          fpu_b <= b_arr[g_idx];
          gid <= g_idx;
          rr_ptr <= (g_idx == IW'(NREQ - 1)) ? '0 : g_idx + IW'(1);
          wd_cnt <= '0;
        end
        BUSY: begin
          wd_cnt <= (fpu_done || wd_hit) ? '0 : wd_cnt + CW'(1);
          if (fpu_done || wd_hit) begin
            rsp_data <= fpu_done ? fpu_out : '0;
            rsp_err <= !fpu_done;
          end
        end
        RELEASE: begin
          wd_cnt <= wd_cnt + CW'(1);
          if (fpu_done && wd_hit) rsp_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_share_ctrl.sv
// tb_fpu_share_ctrl: table vectors plus corner sequences, responses checked against a scoreboard queue
module tb_fpu_share_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] req_valid = '0;
  logic [3:0] req_op = '0;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic [1:0] req_ready;
  logic rsp_valid;
  logic rsp_ready = 1'b1;
  logic [0:0] rsp_id;
  logic [31:0] rsp_data;
  logic rsp_err, fpu_start;
  logic [1:0] fpu_op;
  logic [31:0] fpu_a, fpu_b, fpu_out;
  logic fpu_done;

  typedef struct {int id; logic [1:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] res; int lat;} vec_t;
  typedef struct {int id; logic [31:0] data; logic err;} exp_t;
  vec_t vt [5];
  exp_t sb [$];
  exp_t e;
  int tests = 0, fails = 0, viol = 0;
  int lat = 5, sticky_n = 0, cnt = 0, stick = 0;
  logic hang = 1'b0, stale = 1'b0, prev_start = 1'b0, core;
  logic [31:0] fpu_res = '0;
  localparam logic [31:0] A0 = 32'h0000_1000, A1 = 32'h0000_2000;

  always #5 clk = ~clk;

  fpu_share_ctrl #(.NREQ(2), .W(32), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .fpu_start(fpu_start), .fpu_op(fpu_op),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_out(fpu_out), .fpu_done(fpu_done)
  );

  // FPU stub: done after lat cycles of start, drops with start unless held sticky, never when hung
  assign core = fpu_start && !hang && cnt >= lat;
  assign fpu_done = core || stick > 0 || stale;
  assign fpu_out = fpu_res;
  always @(posedge clk) begin
    cnt <= fpu_start ? cnt + 1 : 0;
    stick <= (fpu_start && core) ? sticky_n : (!fpu_start && stick > 0) ? stick - 1 : stick;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // scoreboard consumer and stale-done start monitor
  always @(negedge clk) begin
    if (fpu_start && !prev_start && fpu_done) viol <= viol + 1;
    prev_start <= fpu_start;
    if (!reset && rsp_valid && rsp_ready) begin
      chk("sb_nonempty", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_err", rsp_err, e.err);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int id, output int ok);
    ok = 0;
    for (int n = 0; n < 100 && ok == 0; n++) begin
      @(negedge clk);
      ok = int'(((req_ready >> id) & 2'b01) != 0);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && sb.size() > 0; n++) @(negedge clk);
    chk("drain", sb.size(), 0);
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_start", fpu_start, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_fpu_op", fpu_op, 0);
    chk("rst_fpu_a", fpu_a, 0);
    chk("rst_fpu_b", fpu_b, 0);
  endtask

  task automatic run_req(input vec_t r, input int extra);
    int ok, n;
    step();
    lat = r.lat;
    fpu_res = r.res;
    rsp_ready = 1'b1;
    req_op = 4'(r.op) << (2 * r.id);
    req_a = 64'(r.a) << (32 * r.id);
    req_b = 64'(r.b) << (32 * r.id);
    req_valid = 2'b01 << r.id;
    wait_acc(r.id, ok);
    chk("accept", ok, 1);
    if (ok != 0) begin
      sb.push_back('{r.id, r.res, 1'b0});
      step();
      req_valid = '0;
      @(negedge clk);
      chk("start", fpu_start, 1);
      chk("fpu_op", fpu_op, r.op);
      chk("fpu_a", fpu_a, r.a);
      chk("fpu_b", fpu_b, r.b);
      n = 1;
      while (!rsp_valid && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("latency", n, r.lat + 3 + extra);
    end
  endtask

  initial begin
    int ok, n;
    vt[0] = '{0, 2'b00, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 5};
    vt[1] = '{1, 2'b01, 32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 3};
    vt[2] = '{0, 2'b10, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 1};
    vt[3] = '{1, 2'b11, 32'hCAFE_0001, 32'h0BAD_F00D, 32'h7777_8888, 7};
    vt[4] = '{1, 2'b00, 32'h0123_4567, 32'h89AB_CDEF, 32'h5555_AAAA, 4};
    req_valid = 2'b01;
    do_reset();
    for (int i = 0; i < 5; i++) run_req(vt[i], 0);
    // round robin with both requesters held valid
    step();
    req_op = '0;
    req_a = {A1, A0};
    req_b = 64'h1;
    req_valid = 2'b11;
    lat = 2;
    fpu_res = 32'h1234_5678;
    do_reset();
    for (int g = 0; g < 4; g++) begin
      ok = 0;
      for (int k = 0; k < 100 && ok == 0; k++) begin
        @(negedge clk);
        ok = int'(req_ready != 0);
      end
      chk("rr_any", ok, 1);
      chk("rr_grant", req_ready, (g % 2 == 1) ? 2'b10 : 2'b01);
      sb.push_back('{g % 2, fpu_res, 1'b0});
      @(negedge clk);
      chk("rr_fpu_a", fpu_a, (g % 2 == 1) ? A1 : A0);
    end
    step();
    req_valid = '0;
    drain();
    // response backpressure with req1 waiting
    step();
    rsp_ready = 1'b0;
    lat = 3;
    fpu_res = 32'hA5A5_0001;
    req_valid = 2'b01;
    wait_acc(0, ok);
    chk("bp_accept", ok, 1);
    sb.push_back('{0, 32'hA5A5_0001, 1'b0});
    step();
    req_valid = 2'b10;
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_id", rsp_id, 0);
      chk("bp_data", rsp_data, 32'hA5A5_0001);
      chk("bp_ready", req_ready, 0);
    end
    step();
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_next_accept", req_ready, 2'b10);
    fpu_res = 32'hA5A5_0002;
    sb.push_back('{1, 32'hA5A5_0002, 1'b0});
    step();
    req_valid = '0;
    drain();
    // watchdog on a hung FPU, then normal service
    step();
    hang = 1'b1;
    fpu_res = 32'hDEAD_BEEF;
    req_valid = 2'b01;
    wait_acc(0, ok);
    chk("wd_accept", ok, 1);
    sb.push_back('{0, 32'h0, 1'b1});
    step();
    req_valid = '0;
    @(negedge clk);
    n = 0;
    while (fpu_start && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("wd_start_cycles", n, 64);
    hang = 1'b0;
    drain();
    run_req(vt[1], 0);
    // stale done in IDLE blocks acceptance, then sticky done delays response
    step();
    stale = 1'b1;
    req_valid = 2'b10;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (req_ready != 0 || fpu_start) n++;
    end
    chk("stale_block", n, 0);
    req_valid = '0;
    stale = 1'b0;
    sticky_n = 3;
    run_req(vt[4], 3);
    step();
    sticky_n = 0;
    drain();
    // reset two cycles into BUSY discards the operation and the pointer
    step();
    lat = 20;
    req_op = '0;
    req_a = {A1, A0};
    req_valid = 2'b01;
    wait_acc(0, ok);
    chk("mb_accept", ok, 1);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("mb_start", fpu_start, 1);
    step();
    do_reset();
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) n++;
    end
    chk("mb_no_rsp", n, 0);
    step();
    lat = 2;
    fpu_res = 32'h0F0F_0F0F;
    req_valid = 2'b11;
    ok = 0;
    for (int k = 0; k < 100 && ok == 0; k++) begin
      @(negedge clk);
      ok = int'(req_ready != 0);
    end
    chk("mb_rr_ptr", req_ready, 2'b01);
    sb.push_back('{0, 32'h0F0F_0F0F, 1'b0});
    step();
    req_valid = '0;
    drain();
    repeat (3) @(negedge clk);
    chk("start_while_done", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fpu_share_ctrl.md
Name: fpu_share_ctrl

Overview:
- Round-robin scheduler that shares one multi-cycle floating-point unit (add/mult, start/done handshake) between NREQ requesters.
- Accepts one request, holds the operands stable, drives the FPU start/done protocol, and returns the result on a shared response channel tagged with the requester id.
- A watchdog aborts a hung FPU operation and reports an error.
- Sits between the client ports and the FPU top level.

Parameters:
- NREQ, 2, number of requesters (2..8).
- W, 32, operand/result width (IEEE-754 single).
- TIMEOUT, 64, maximum cycles spent waiting in each of BUSY and RELEASE before abort (≥4).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_op  in  2*NREQ  per-requester opcode; slice i is [2i+1:2i].
- req_a  in  W*NREQ  per-requester operand A.
- req_b  in  W*NREQ  per-requester operand B.
- req_ready  out  NREQ  one-hot accept; at most one bit high.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  $clog2(NREQ)  requester index of the response.
- rsp_data  out  W  result.
- rsp_err  out  1  timeout abort flag.
- fpu_start  out  1  FPU start level.
- fpu_op  out  2  opcode to FPU.
- fpu_a  out  W  operand A to FPU.
- fpu_b  out  W  operand B to FPU.
- fpu_out  in  W  FPU result.
- fpu_done  in  1  FPU done; held high until start drops.

Behaviour:
- Reset (sync): state=IDLE, rr_ptr=0, wd_cnt=0. fpu_start, rsp_valid, rsp_err, rsp_data, rsp_id, fpu_op, fpu_a and fpu_b all 0. req_ready=0 on the cycle after reset is sampled. Reset mid-operation drops fpu_start immediately and discards the operation; no response is issued.
- States: IDLE, BUSY, RELEASE, RESP.
- IDLE:
  - Only state in which req_ready may be nonzero, and only when fpu_done=0.
  - req_ready = combinational one-hot grant: first requester with valid set, searching from rr_ptr upward with wrap.
  - On accept (req_valid[g] & req_ready[g]), at cycle T: latch op/a/b into fpu_op/fpu_a/fpu_b, set gid=g, rr_ptr=(g+1) mod NREQ, wd_cnt=0, go BUSY.
  - fpu_start=1 from T+1.
- BUSY:
  - fpu_start=1; operands are stable and unchanged.
  - fpu_done=1 sampled: capture fpu_out into rsp_data, rsp_err=0, go RELEASE (fpu_start=0 next cycle).
  - Else wd_cnt++. When wd_cnt==TIMEOUT-1: rsp_data=0, rsp_err=1, go RELEASE.
- RELEASE:
  - fpu_start=0; wait until fpu_done is sampled 0, then go RESP.
  - wd_cnt is cleared on entry. If fpu_done stays high for TIMEOUT cycles, set rsp_err=1 and go RESP.
- RESP:
  - rsp_valid=1, rsp_id=gid; rsp_data/rsp_err held stable.
  - rsp_valid & rsp_ready: go IDLE, next request acceptable the following cycle.
  - rsp_valid stays high under backpressure.
- Minimum latency, accept to rsp_valid: FPU latency L (start→done) + 3 cycles.
- IDLE with fpu_done still high (stale FPU) blocks acceptance.
- req_valid changes or drops in BUSY/RELEASE/RESP have no effect.
- Equal-priority fairness: a requester that stays valid is served within NREQ grants.
- NREQ=1 degenerates to pass-through; rsp_id width is forced to 1.
- Opcodes other than ADD/MUL are passed to the FPU unchanged.

Decomposition:
- Package fpu_pkg:
  - opcode constants FPU_ADD=2'b00, FPU_MUL=2'b01.
  - state encoding localparams IDLE=2'd0, BUSY=2'd1, RELEASE=2'd2, RESP=2'd3.
  - W default.
- Sub-module rr_arbiter: combinational, inputs req[NREQ] and ptr; outputs grant one-hot and grant index. Reused by later shared-resource blocks.

Test Plan:
- Single request:
  - Stimulus: req0 ADD a=0x3F800000, b=0x40000000; FPU model L=5 returns 0x40400000.
  - Required: req_ready[0] at T; fpu_start from T+1; rsp_valid at T+8 with rsp_id=0, rsp_data=0x40400000, rsp_err=0.
- Round-robin:
  - Stimulus: req0 and req1 valid continuously, each re-issued after being served.
  - Required: grants in order 0,1,0,1. After reset rr_ptr=0, so req0 is served first.
- Watchdog:
  - Stimulus: FPU model never raises done, TIMEOUT=64.
  - Required: fpu_start falls 64 cycles after rising; response rsp_err=1, rsp_data=0; controller returns to IDLE and serves the next request normally.
- Response backpressure:
  - Stimulus: rsp_ready=0 for 10 cycles while req1 is valid.
  - Required: rsp_valid, rsp_id and rsp_data stable for those 10 cycles; req_ready stays 0; req1 is accepted the cycle after the handshake.
- Reset mid-BUSY:
  - Stimulus: reset asserted 2 cycles after fpu_start rises.
  - Required: fpu_start=0 and rsp_valid=0 on the next cycle; no response ever emitted; rr_ptr=0.
- Sticky done:
  - Stimulus: FPU holds done 3 cycles after start drops.
  - Required: RESP entered only after done falls; no new fpu_start while done=1.
